// File: rtl/axi_burst_beat_sequencer_pkg.sv
// Shared AXI burst encodings, field widths, FSM states and the beat address stepping function.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package axi_burst_beat_sequencer_pkg;

    localparam int BW_AXI_ALEN   = 8;
    localparam int BW_AXI_ASIZE  = 3;
    localparam int BW_AXI_ABURST = 2;

    localparam logic [BW_AXI_ABURST-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [BW_AXI_ABURST-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [BW_AXI_ABURST-1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic int cmd_rec_width(input int bw_id, input int bw_addr);
        return bw_id + bw_addr + BW_AXI_ALEN + BW_AXI_ASIZE + BW_AXI_ABURST;
    endfunction

    // Computed at 64 bits; callers truncate to their address width, giving INCR its modulo wrap.
    function automatic logic [63:0] next_beat_addr(
        input logic [63:0]              cur,
        input logic [BW_AXI_ALEN-1:0]   len,
        input logic [BW_AXI_ASIZE-1:0]  size,
        input logic [BW_AXI_ABURST-1:0] burst
    );
        logic [63:0] bytes;
        logic [63:0] mask;
        bytes = 64'd1 << size;
        mask  = ((64'(len) + 64'd1) << size) - 64'd1;
        case (burst)
            AXI_BURST_FIXED: next_beat_addr = cur;
            AXI_BURST_WRAP:  next_beat_addr = (cur & ~mask) | ((cur + bytes) & mask);
            default:         next_beat_addr = (cur & ~(bytes - 64'd1)) + bytes;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_beat_sequencer_if.sv
// Command-in / beat-out bundle of the burst beat sequencer; slave = sequencer side.
// No logic, no latency.
// Backpressure: cmd_valid/cmd_ready and beat_valid/beat_ready handshakes.
interface axi_burst_beat_sequencer_if
    import axi_burst_beat_sequencer_pkg::*;
#(
    parameter int BW_ADDR = 32,
    parameter int BW_DATA = 64,
    parameter int BW_ID   = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [BW_ID-1:0]         cmd_id;
    logic [BW_ADDR-1:0]       cmd_addr;
    logic [BW_AXI_ALEN-1:0]   cmd_len;
    logic [BW_AXI_ASIZE-1:0]  cmd_size;
    logic [BW_AXI_ABURST-1:0] cmd_burst;
    logic                     beat_valid;
    logic                     beat_ready;
    logic [BW_ID-1:0]         beat_id;
    logic [BW_ADDR-1:0]       beat_addr;
    logic [BW_AXI_ALEN-1:0]   beat_index;
    logic                     beat_last;
    logic [BW_DATA/8-1:0]     beat_strb;
    logic                     busy;
    logic                     cmd_err;

    modport master (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_id, beat_addr, beat_index, beat_last, beat_strb,
               busy, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_id, beat_addr, beat_index, beat_last, beat_strb,
               busy, cmd_err
    );
endinterface

// File: rtl/axi_burst_cmd_fifo.sv
// Small command FIFO with registered occupancy count and full/empty flags.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; full ignores a same-cycle pop.
module axi_burst_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = push && !full;
    assign rd_ok   = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/axi_burst_beat_sequencer.sv
// Burst-to-beat sequencer: queues AXI burst commands, emits one addressed beat per handshake.
// Latency: first beat valid the cycle after acceptance; back-to-back bursts without a bubble.
// Backpressure: beats held while beat_ready low; cmd_ready low when FIFO full. Option macro: AXI_BEAT_STRB_EN.
module axi_burst_beat_sequencer
    import axi_burst_beat_sequencer_pkg::*;
#(
    parameter int BW_ADDR   = 32,
    parameter int BW_DATA   = 64,
    parameter int BW_ID     = 4,
    parameter int CMD_DEPTH = 2
) (
    input logic                       clk,
    input logic                       rstnn,
    axi_burst_beat_sequencer_if.slave bus
);
    localparam int B     = BW_DATA / 8;
    localparam int REC_W = cmd_rec_width(BW_ID, BW_ADDR);
    localparam logic [BW_AXI_ASIZE-1:0] SIZE_MAX = BW_AXI_ASIZE'($clog2(B));

    typedef struct packed {
        logic [BW_ID-1:0]         id;
        logic [BW_ADDR-1:0]       addr;
        logic [BW_AXI_ALEN-1:0]   len;
        logic [BW_AXI_ASIZE-1:0]  size;
        logic [BW_AXI_ABURST-1:0] burst;
    } cmd_t;

    state_t                   state, state_nxt;
    cmd_t                     cmd_in, head, src;
    logic                     bad_burst, bad_size, cmd_push;
    logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                     load, beat_hs, advance;
    logic [BW_ID-1:0]         id_q;
    logic [BW_ADDR-1:0]       addr_q, addr_nxt;
    logic [BW_AXI_ALEN-1:0]   idx_q, len_q;
    logic [BW_AXI_ASIZE-1:0]  size_q;
    logic [BW_AXI_ABURST-1:0] burst_q;
    logic                     last_q, err_q;

    // Illegal bursts and oversize beats are repaired before queueing, so the datapath never sees them.
    always_comb begin
        cmd_in    = '{id: bus.cmd_id, addr: bus.cmd_addr, len: bus.cmd_len,
                      size: bus.cmd_size, burst: bus.cmd_burst};
        bad_burst = (bus.cmd_burst == 2'b11) ||
                    ((bus.cmd_burst == AXI_BURST_WRAP) &&
                     !(bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        bad_size  = (bus.cmd_size > SIZE_MAX);
        if (bad_burst) cmd_in.burst = AXI_BURST_INCR;
        if (bad_size)  cmd_in.size  = SIZE_MAX;
    end

    assign cmd_push  = bus.cmd_valid && !fifo_full;
    assign beat_hs   = (state == ST_ACTIVE) && bus.beat_ready;
    assign advance   = beat_hs && !last_q;
    // An empty FIFO with a same-cycle push feeds the beat registers directly.
    assign src       = fifo_empty ? cmd_in : head;
    assign fifo_pop  = load && !fifo_empty;
    assign fifo_push = cmd_push && !(load && fifo_empty);
    assign addr_nxt  = BW_ADDR'(next_beat_addr(64'(addr_q), len_q, size_q, burst_q));

    axi_burst_cmd_fifo #(
        .WIDTH (REC_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rstnn    (rstnn),
        .push     (fifo_push),
        .push_dat (cmd_in),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty || cmd_push) begin
                    load      = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (beat_hs && last_q) begin
                    if (!fifo_empty || cmd_push) load = 1'b1;
                    else                         state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            id_q    <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= cmd_push && (bad_burst || bad_size);
            if (load) begin
                id_q    <= src.id;
                addr_q  <= src.addr;
                idx_q   <= '0;
                len_q   <= src.len;
                size_q  <= src.size;
                burst_q <= src.burst;
                last_q  <= (src.len == '0);
            end else if (advance) begin
                addr_q <= addr_nxt;
                idx_q  <= idx_q + 8'd1;
                last_q <= ((idx_q + 8'd1) == len_q);
            end
        end
    end

`ifdef AXI_BEAT_STRB_EN
    function automatic logic [B-1:0] lane_mask(input logic [BW_ADDR-1:0] a,
                                               input logic [BW_AXI_ASIZE-1:0] sz);
        logic [BW_ADDR-1:0] lo;
        logic [BW_ADDR-1:0] hi;
        lo = a & BW_ADDR'(B - 1);
        hi = (a | ((BW_ADDR'(1) << sz) - BW_ADDR'(1))) & BW_ADDR'(B - 1);
        for (int i = 0; i < B; i++) lane_mask[i] = (BW_ADDR'(i) >= lo) && (BW_ADDR'(i) <= hi);
    endfunction

    logic [B-1:0] strb_q;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)       strb_q <= '0;
        else if (load)    strb_q <= lane_mask(src.addr, src.size);
        else if (advance) strb_q <= lane_mask(addr_nxt, size_q);
    end

    assign bus.beat_strb = strb_q;
`else
    assign bus.beat_strb = '1;
`endif

    assign bus.cmd_ready  = !fifo_full;
    assign bus.beat_valid = (state == ST_ACTIVE);
    assign bus.beat_id    = id_q;
    assign bus.beat_addr  = addr_q;
    assign bus.beat_index = idx_q;
    assign bus.beat_last  = last_q;
    assign bus.busy       = (state == ST_ACTIVE) || !fifo_empty;
    assign bus.cmd_err    = err_q;
endmodule

// File: tb/tb_axi_burst_beat_sequencer.sv
// Directed bench for axi_burst_beat_sequencer: burst vector table plus back-to-back, full-FIFO, stall and reset sequences.
module tb_axi_burst_beat_sequencer;
    import axi_burst_beat_sequencer_pkg::*;

    logic clk   = 1'b0;
    logic rstnn = 1'b0;
    always #5 clk = ~clk;

    axi_burst_beat_sequencer_if #(.BW_ADDR(32), .BW_DATA(64), .BW_ID(4)) bus ();

    axi_burst_beat_sequencer #(
        .BW_ADDR   (32),
        .BW_DATA   (64),
        .BW_ID     (4),
        .CMD_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rstnn (rstnn),
        .bus   (bus)
    );

`ifdef AXI_BEAT_STRB_EN
    localparam bit         STRB_EN  = 1'b1;
    localparam logic [7:0] STRB_RST = 8'h00;
`else
    localparam bit         STRB_EN  = 1'b0;
    localparam logic [7:0] STRB_RST = 8'hFF;
`endif

    typedef struct {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic             err;
        logic [3:0][31:0] ea;
        logic [3:0][7:0]  es;
    } vec_t;

    int   n_chk = 0;
    int   n_err = 0;
    vec_t vecs[10];

    function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                input logic [1:0] b, input logic [3:0] id, input logic e,
                                input logic [31:0] a0, a1, a2, a3,
                                input logic [7:0] s0, s1, s2, s3);
        vec_t v;
        v.addr = a; v.len = l; v.size = s; v.burst = b; v.id = id; v.err = e;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
        v.es[0] = s0; v.es[1] = s1; v.es[2] = s2; v.es[3] = s3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [3:0] id);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_size  = s;
        bus.cmd_burst = b;
        bus.cmd_id    = id;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [7:0] idx,
                            input logic last, input logic [3:0] id, input logic [7:0] s);
        chk({tag, ".valid"}, 32'(bus.beat_valid), 32'd1);
        chk({tag, ".addr"},  bus.beat_addr, a);
        chk({tag, ".index"}, 32'(bus.beat_index), 32'(idx));
        chk({tag, ".last"},  32'(bus.beat_last), 32'(last));
        chk({tag, ".id"},    32'(bus.beat_id), 32'(id));
        chk({tag, ".strb"},  32'(bus.beat_strb), STRB_EN ? 32'(s) : 32'hFF);
    endtask

    initial begin
        vecs[0] = mk(32'h1004, 3, 2, AXI_BURST_INCR, 1, 0, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 8'hF0, 8'h0F, 8'hF0, 8'h0F);
        vecs[1] = mk(32'h2038, 3, 3, AXI_BURST_WRAP, 2, 0, 32'h2038, 32'h2020, 32'h2028, 32'h2030, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        vecs[2] = mk(32'h3002, 2, 1, AXI_BURST_FIXED, 3, 0, 32'h3002, 32'h3002, 32'h3002, 0, 8'h0C, 8'h0C, 8'h0C, 0);
        vecs[3] = mk(32'h1003, 1, 2, AXI_BURST_INCR, 4, 0, 32'h1003, 32'h1004, 0, 0, 8'h08, 8'hF0, 0, 0);
        vecs[4] = mk(32'h4000, 2, 2, AXI_BURST_WRAP, 5, 1, 32'h4000, 32'h4004, 32'h4008, 0, 8'h0F, 8'hF0, 8'h0F, 0);
        vecs[5] = mk(32'h5000, 1, 4, AXI_BURST_INCR, 6, 1, 32'h5000, 32'h5008, 0, 0, 8'hFF, 8'hFF, 0, 0);
        vecs[6] = mk(32'h6010, 1, 3, 2'b11, 7, 1, 32'h6010, 32'h6018, 0, 0, 8'hFF, 8'hFF, 0, 0);
        vecs[7] = mk(32'hFFFFFFF8, 1, 3, AXI_BURST_INCR, 8, 0, 32'hFFFFFFF8, 32'h0, 0, 0, 8'hFF, 8'hFF, 0, 0);
        vecs[8] = mk(32'h7004, 1, 2, AXI_BURST_WRAP, 9, 0, 32'h7004, 32'h7000, 0, 0, 8'hF0, 8'h0F, 0, 0);
        vecs[9] = mk(32'h0, 0, 0, AXI_BURST_INCR, 15, 0, 32'h0, 0, 0, 0, 8'h01, 0, 0, 0);

        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_size = '0;
        bus.cmd_burst = '0; bus.cmd_id = '0; bus.beat_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.beat_valid", 32'(bus.beat_valid), 0);
        chk("rst.beat_last",  32'(bus.beat_last), 0);
        chk("rst.beat_addr",  bus.beat_addr, 0);
        chk("rst.beat_index", 32'(bus.beat_index), 0);
        chk("rst.beat_id",    32'(bus.beat_id), 0);
        chk("rst.beat_strb",  32'(bus.beat_strb), 32'(STRB_RST));
        chk("rst.busy",       32'(bus.busy), 0);
        chk("rst.cmd_err",    32'(bus.cmd_err), 0);
        rstnn = 1'b1;
        tick();
        chk("rst.cmd_ready", 32'(bus.cmd_ready), 1);

        for (int i = 0; i < 10; i++) begin
            drive_cmd(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].id);
            chk($sformatf("v%0d.cmd_ready", i), 32'(bus.cmd_ready), 1);
            tick();
            bus.cmd_valid = 1'b0;
            chk($sformatf("v%0d.cmd_err", i), 32'(bus.cmd_err), 32'(vecs[i].err));
            bus.beat_ready = 1'b1;
            for (int k = 0; k <= int'(vecs[i].len); k++) begin
                if (k == 1) chk($sformatf("v%0d.err_pulse", i), 32'(bus.cmd_err), 0);
                chk_beat($sformatf("v%0d.b%0d", i, k), vecs[i].ea[k], 8'(k),
                         k == int'(vecs[i].len), vecs[i].id, vecs[i].es[k]);
                tick();
            end
            bus.beat_ready = 1'b0;
            chk($sformatf("v%0d.end_valid", i), 32'(bus.beat_valid), 0);
            chk($sformatf("v%0d.end_busy", i), 32'(bus.busy), 0);
        end

        // Two single-beat bursts with the sink always ready: valid on consecutive cycles.
        bus.beat_ready = 1'b1;
        drive_cmd(32'h100, 0, 3, AXI_BURST_INCR, 7);
        tick();
        drive_cmd(32'h200, 0, 3, AXI_BURST_INCR, 8);
        chk_beat("b2b.a", 32'h100, 0, 1, 7, 8'hFF);
        tick();
        bus.cmd_valid = 1'b0;
        chk_beat("b2b.b", 32'h200, 0, 1, 8, 8'hFF);
        tick();
        chk("b2b.end_valid", 32'(bus.beat_valid), 0);

        // Fill the FIFO behind a stalled burst, then drain with zero bubbles.
        bus.beat_ready = 1'b0;
        drive_cmd(32'h100, 0, 3, AXI_BURST_INCR, 1);
        tick();
        drive_cmd(32'h200, 0, 3, AXI_BURST_INCR, 2);
        chk("full.rdy_b", 32'(bus.cmd_ready), 1);
        tick();
        drive_cmd(32'h300, 0, 3, AXI_BURST_INCR, 3);
        tick();
        drive_cmd(32'h400, 0, 3, AXI_BURST_INCR, 4);
        chk("full.rdy_d", 32'(bus.cmd_ready), 0);
        chk("full.busy", 32'(bus.busy), 1);
        chk_beat("full.a", 32'h100, 0, 1, 1, 8'hFF);
        bus.beat_ready = 1'b1;
        tick();
        chk("full.rdy_after_pop", 32'(bus.cmd_ready), 1);
        chk_beat("full.b", 32'h200, 0, 1, 2, 8'hFF);
        tick();
        bus.cmd_valid = 1'b0;
        chk_beat("full.c", 32'h300, 0, 1, 3, 8'hFF);
        tick();
        chk_beat("full.d", 32'h400, 0, 1, 4, 8'hFF);
        tick();
        chk("full.end_valid", 32'(bus.beat_valid), 0);
        chk("full.end_busy", 32'(bus.busy), 0);

        // Stall mid-burst, then reset at beat 2 with a command still queued.
        bus.beat_ready = 1'b0;
        drive_cmd(32'h8000, 3, 3, AXI_BURST_INCR, 9);
        tick();
        drive_cmd(32'h9000, 0, 3, AXI_BURST_INCR, 10);
        chk_beat("stall.b0", 32'h8000, 0, 0, 9, 8'hFF);
        bus.beat_ready = 1'b1;
        tick();
        bus.cmd_valid  = 1'b0;
        bus.beat_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk_beat($sformatf("stall.hold%0d", c), 32'h8008, 1, 0, 9, 8'hFF);
            tick();
        end
        chk_beat("stall.b1", 32'h8008, 1, 0, 9, 8'hFF);
        bus.beat_ready = 1'b1;
        tick();
        bus.beat_ready = 1'b0;
        chk_beat("stall.b2", 32'h8010, 2, 0, 9, 8'hFF);
        rstnn = 1'b0;
        #1;
        chk("mrst.beat_valid", 32'(bus.beat_valid), 0);
        chk("mrst.busy",       32'(bus.busy), 0);
        chk("mrst.beat_addr",  bus.beat_addr, 0);
        chk("mrst.beat_index", 32'(bus.beat_index), 0);
        chk("mrst.beat_strb",  32'(bus.beat_strb), 32'(STRB_RST));
        #2;
        rstnn = 1'b1;
        repeat (3) tick();
        chk("mrst.lost_valid", 32'(bus.beat_valid), 0);
        chk("mrst.lost_busy",  32'(bus.busy), 0);
        chk("mrst.cmd_ready",  32'(bus.cmd_ready), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
